sw_led_ctrl: RTL and testbench
==============================

Name: sw_led_ctrl

Overview:
- Parametrised successor to the fixed 4-switch/4-LED top-level logic.
- Per channel: synchronises and debounces NUM_CH switch inputs, and produces one-cycle rising-edge pulses.
- Drives NUM_CH LEDs in one of four runtime-selectable modes: direct, toggle, blink, edge count.
- Sits between board pins and top-level user logic; `sw_stable` and `sw_rise` are also exported for other consumers.

Parameters:
- NUM_CH, 4, number of switch/LED channels (>=1).
- DEBOUNCE_CYCLES, 1000000, consecutive cycles an input must differ from the stable value before it is accepted (>=1).
- BLINK_DIV, 50000000, half-period of the blink waveform in clk cycles (>=1).

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- rst  in  1  asynchronous, active-high reset.
- sw  in  NUM_CH  raw switch inputs, asynchronous to clk.
- mode  in  2  LED mode: 00 DIRECT, 01 TOGGLE, 10 BLINK, 11 COUNT.
- clr  in  1  synchronous clear of toggle and count state.
- led  out  NUM_CH  registered LED drive.
- sw_stable  out  NUM_CH  debounced switch level.
- sw_rise  out  NUM_CH  one-cycle pulse on each debounced 0->1 transition.

Behaviour:
- Reset value: 0 for every flop and every output (sync flops, stable, debounce counters, toggle, count, blink counter/phase, led, sw_rise). Reset asserted mid-debounce discards partial counts.
- Sync: 2-flop synchroniser per channel. Its second stage is the debouncer input.
- Debounce, per channel:
  - Counter increments on each edge where the input differs from stable; it clears to 0 on any edge where they are equal.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge: stable <= input, counter <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge pulse: sw_rise[i] = 1 for exactly the one cycle following the edge where stable[i] goes 0->1. A 1->0 transition produces no pulse.
- Latency (D = DEBOUNCE_CYCLES), with the new sw value first sampled at edge k:
  - stable and sw_rise update at edge k+D+1;
  - led updates at edge k+D+2 in every mode.
- Toggle state: tog[i] inverts at the same edge stable[i] rises.
- Count state: NUM_CH-bit count, incremented by popcount(rising edges) at the same edge, modulo 2^NUM_CH. Simultaneous rises on several channels all count; wrap is silent.
- clr: tog and count go to 0 at the next edge. clr wins over a simultaneous rise. clr has no effect on stable or sw_rise.
- Blink: free-running counter 0..BLINK_DIV-1. blink_phase toggles on the edge where the counter equals BLINK_DIV-1, and the counter wraps to 0 there. Blink is not affected by mode.
- LED register, loaded every edge:
  - DIRECT: led <= stable
  - TOGGLE: led <= tog
  - BLINK: led <= stable & {NUM_CH{blink_phase}}
  - COUNT: led <= count
- mode change takes effect on led at the next edge. tog and count keep updating in every mode.

Optional Feature:
- Macro: SW_LED_SYNC_EN.
- Defined: the 2-flop synchroniser is present, and the latencies above apply.
- Undefined: raw sw feeds the debouncer directly (for synchronous stimulus only). Each latency is reduced by 2: stable/sw_rise at edge k+D-1, led at k+D.

Decomposition:
- Package sw_led_pkg holds:
  - typedef enum logic [1:0] led_mode_e {MODE_DIRECT, MODE_TOGGLE, MODE_BLINK, MODE_COUNT};
  - mode encoding constants.
- Sub-module sw_debounce: one channel containing the synchroniser (under the macro), debounce counter, stable and rise registers. It is generate-instantiated NUM_CH times.
- Toggle, count, blink and led mux stay in sw_led_ctrl.

Test Plan:
All cases use NUM_CH=4, DEBOUNCE_CYCLES=4, BLINK_DIV=8, SW_LED_SYNC_EN defined.
1. Reset: rst=1 for 3 cycles with sw=1111, mode=00 -> led=0000, sw_stable=0000, sw_rise=0000 throughout; all stay 0 until 5 edges after release.
2. Direct latency: mode=00, sw 0000->0001 sampled at edge k -> sw_rise=0001 for one cycle after edge k+5; led=0001 from edge k+6.
3. Glitch rejection: sw[1] high for 3 cycles then low -> sw_stable, sw_rise and led unchanged. A 4-cycle pulse is accepted.
4. Toggle: mode=01, two clean press/release cycles on sw[2] -> led=0100 after the first press, 0000 after the second. Releases do not change led.
5. Count/clr: mode=11, sw 0000->1111 -> led=0100. Release all, press again -> led=1000. clr=1 for one cycle coincident with a rise -> led=0000.
6. Blink and reset mid-operation: mode=10, sw stable 0001 -> led[0] high 8 cycles, low 8 cycles, repeating; led[3:1]=0. rst pulsed while sw[3] is mid-debounce -> all outputs 0 and the debounce restarts from 0.

Source files
------------

// File: rtl/sw_led_pkg.sv
// Shared types for the switch/LED controller: LED mode encoding.
package sw_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_COUNT  = 2'b11
    } led_mode_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: optional 2-flop synchroniser (SW_LED_SYNC_EN), debounce
// counter, debounced level and a registered one-cycle rising-edge pulse.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_stable,
    output logic o_rise,
    output logic o_rise_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          w_in;
    logic          w_diff;
    logic          w_accept;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_rise;

`ifdef SW_LED_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_in = r_sync2;
`else
    assign w_in = i_sw;
`endif

    assign w_diff   = w_in ^ r_stable;
    // The current edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_rise <= w_accept & w_in;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt    <= '0;
                r_stable <= w_in;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable   = r_stable;
    assign o_rise     = r_rise;
    assign o_rise_evt = w_accept & w_in;

endmodule

// File: rtl/sw_led_ctrl.sv
// Debounced switches driving LEDs in direct/toggle/blink/count modes.
// SW_LED_SYNC_EN enables the per-channel input synchroniser in sw_debounce.
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_DIV       = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw,
    input  logic [1:0]        mode,
    input  logic              clr,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] sw_stable,
    output logic [NUM_CH-1:0] sw_rise
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [NUM_CH-1:0] w_rise_evt;
    logic [NUM_CH-1:0] w_count_nxt;
    logic [NUM_CH-1:0] w_led_nxt;
    logic [NUM_CH-1:0] r_tog;
    logic [NUM_CH-1:0] r_count;
    logic [NUM_CH-1:0] r_led;
    logic [BW-1:0]     r_blink_cnt;
    logic              r_blink_phase;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .i_sw      (sw[i]),
            .o_stable  (sw_stable[i]),
            .o_rise    (sw_rise[i]),
            .o_rise_evt(w_rise_evt[i])
        );
    end

    // Simultaneous rises all count; the sum wraps modulo 2^NUM_CH.
    always_comb begin
        w_count_nxt = r_count;
        for (int i = 0; i < NUM_CH; i++) begin
            w_count_nxt = w_count_nxt + NUM_CH'(w_rise_evt[i]);
        end
    end

    always_comb begin
        w_led_nxt = sw_stable;
        case (led_mode_e'(mode))
            MODE_DIRECT: w_led_nxt = sw_stable;
            MODE_TOGGLE: w_led_nxt = r_tog;
            MODE_BLINK:  w_led_nxt = sw_stable & {NUM_CH{r_blink_phase}};
            MODE_COUNT:  w_led_nxt = r_count;
            default:     w_led_nxt = sw_stable;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tog         <= '0;
            r_count       <= '0;
            r_led         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_led <= w_led_nxt;
            if (clr) begin
                r_tog   <= '0;
                r_count <= '0;
            end else begin
                r_tog   <= r_tog ^ w_rise_evt;
                r_count <= w_count_nxt;
            end
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Self-checking bench for sw_led_ctrl with a window-based reference model.
module tb_sw_led_ctrl;

  localparam int NUM_CH = 4;
  localparam int D      = 4;
  localparam int BDIV   = 8;
`ifdef SW_LED_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // tick index (0 = first edge after sw is driven) at which stable/sw_rise update
  localparam int LAT = D + SYNC - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] sw;
  logic [1:0] mode;
  logic [3:0] led;
  logic [3:0] sw_stable;
  logic [3:0] sw_rise;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  // reference model state
  logic [3:0] m_stable, m_tog, m_count, m_led, m_rise;
  logic [3:0] swq[$];
  logic [3:0] winq[$];
  int         m_t;

  // clock / reset block
  always #5 clk = ~clk;

  sw_led_ctrl #(
    .NUM_CH(NUM_CH),
    .DEBOUNCE_CYCLES(D),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .mode(mode),
    .clr(clr),
    .led(led),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise)
  );

  function automatic void model_reset();
    m_stable = '0;
    m_tog    = '0;
    m_count  = '0;
    m_led    = '0;
    m_rise   = '0;
    m_t      = 0;
    swq.delete();
    for (int i = 0; i < SYNC; i++) swq.push_back(4'b0000);
    winq.delete();
  endfunction

  // A channel's stable value flips when its last D debouncer samples all differ from it.
  function automatic void model_step();
    logic [3:0] in_v, nst, rise;
    logic       ph;
    bit         all_diff;
    swq.push_back(sw);
    in_v = swq.pop_front();
    winq.push_back(in_v);
    if (winq.size() > D) void'(winq.pop_front());
    ph = ((m_t / BDIV) % 2) == 1;
    case (mode)
      2'd0:    m_led = m_stable;
      2'd1:    m_led = m_tog;
      2'd2:    m_led = m_stable & {4{ph}};
      default: m_led = m_count;
    endcase
    nst  = m_stable;
    rise = '0;
    if (winq.size() == D) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        all_diff = 1;
        foreach (winq[j]) if (winq[j][ch] == m_stable[ch]) all_diff = 0;
        if (all_diff) begin
          nst[ch]  = ~m_stable[ch];
          rise[ch] = nst[ch];
        end
      end
    end
    m_tog    = clr ? 4'b0000 : (m_tog ^ rise);
    m_count  = clr ? 4'b0000 : (m_count + 4'($countones(rise)));
    m_stable = nst;
    m_rise   = rise;
    m_t++;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    sw = 4'hF; mode = 2'b00; clr = 1'b0; rst = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if ({led, sw_stable, sw_rise} !== 12'h000)
        $display("FAIL reset_hold: got %h expected 000", {led, sw_stable, sw_rise});
      else n_pass++;
    end
    rst = 1'b0;
    repeat (LAT) begin
      tick();
      n_checks++;
      if ({led, sw_stable, sw_rise} !== 12'h000)
        $display("FAIL reset_release_quiet: got %h expected 000", {led, sw_stable, sw_rise});
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({sw_stable, sw_rise} !== 8'hFF)
      $display("FAIL reset_first_accept: got %h expected ff", {sw_stable, sw_rise});
    else n_pass++;
    tick();
    n_checks++;
    if ({led, sw_rise} !== 8'hF0)
      $display("FAIL reset_first_led: got %h expected f0", {led, sw_rise});
    else n_pass++;
    sw = 4'h0;
    hold(LAT + 3);
  endtask

  task automatic test_direct_latency();
    logic [7:0] e;
    mode = 2'b00;
    sw   = 4'b0001;
    for (int i = 0; i <= LAT + 2; i++)
      exp_q.push_back({(i == LAT) ? 4'b0001 : 4'b0000, (i >= LAT + 1) ? 4'b0001 : 4'b0000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      n_checks++;
      if ({sw_rise, led} !== e)
        $display("FAIL direct_latency: got rise/led %h expected %h", {sw_rise, led}, e);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int seen;
    sw = 4'b0011;
    hold(3);
    sw = 4'b0001;
    repeat (LAT + 3) begin
      tick();
      n_checks++;
      if ({sw_stable, sw_rise, led} !== 12'h101)
        $display("FAIL glitch_reject: got %h expected 101", {sw_stable, sw_rise, led});
      else n_pass++;
    end
    sw   = 4'b0011;
    seen = 0;
    for (int i = 0; i < LAT + 7; i++) begin
      if (i == 4) sw = 4'b0001;
      tick();
      if (sw_rise[1]) seen++;
    end
    n_checks++;
    if (seen != 1) $display("FAIL glitch_accept4: got %0d rise pulses expected 1", seen);
    else n_pass++;
    n_checks++;
    if (sw_stable !== 4'b0001)
      $display("FAIL glitch_accept4_return: got %b expected 0001", sw_stable);
    else n_pass++;
  endtask

  task automatic test_toggle();
    logic [3:0] pat [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
    logic [3:0] want[4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    sw = 4'b0000;
    hold(LAT + 3);
    mode = 2'b01;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    n_checks++;
    if (led !== 4'b0000) $display("FAIL toggle_clear: got %b expected 0000", led);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sw = pat[i];
      hold(LAT + 3);
      n_checks++;
      if (led !== want[i]) $display("FAIL toggle_step%0d: got %b expected %b", i, led, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_count_clr();
    logic [3:0] pat [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic [3:0] want[4] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000};
    mode = 2'b11;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    n_checks++;
    if (led !== 4'b0000) $display("FAIL count_clear: got %b expected 0000", led);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sw = pat[i];
      hold(LAT + 3);
      n_checks++;
      if (led !== want[i]) $display("FAIL count_step%0d: got %b expected %b", i, led, want[i]);
      else n_pass++;
    end
    sw = 4'hF;
    hold(LAT);
    clr = 1'b1;
    tick();
    n_checks++;
    if (sw_rise !== 4'hF) $display("FAIL clr_rise_unaffected: got %b expected 1111", sw_rise);
    else n_pass++;
    clr = 1'b0;
    tick();
    n_checks++;
    if (led !== 4'b0000) $display("FAIL clr_wins: got %b expected 0000", led);
    else n_pass++;
    hold(3);
    n_checks++;
    if (led !== 4'b0000) $display("FAIL clr_after: got %b expected 0000", led);
    else n_pass++;
  endtask

  task automatic test_blink_reset();
    int highs;
    mode = 2'b10;
    sw   = 4'b0001;
    hold(LAT + 3);
    highs = 0;
    repeat (4 * BDIV) begin
      tick();
      highs += int'(led[0]);
      n_checks++;
      if (led !== m_led || led[3:1] !== 3'b000)
        $display("FAIL blink_led: got %b expected %b", led, m_led);
      else n_pass++;
    end
    n_checks++;
    if (highs != 2 * BDIV) $display("FAIL blink_duty: got %0d high cycles expected %0d", highs, 2 * BDIV);
    else n_pass++;
    sw = 4'b1001;
    hold(SYNC + 2);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({led, sw_stable, sw_rise} !== 12'h000)
      $display("FAIL midreset_outputs: got %h expected 000", {led, sw_stable, sw_rise});
    else n_pass++;
    rst = 1'b0;
    repeat (LAT) begin
      tick();
      n_checks++;
      if (sw_stable !== 4'b0000) $display("FAIL midreset_restart: got %b expected 0000", sw_stable);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (sw_stable !== 4'b1001) $display("FAIL midreset_accept: got %b expected 1001", sw_stable);
    else n_pass++;
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (left == 0) begin
        sw   = sw ^ 4'($urandom_range(0, 15));
        left = $urandom_range(1, 2 * D + 2);
      end
      left--;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
      n_checks++;
      if ({led, sw_stable, sw_rise} !== {m_led, m_stable, m_rise})
        $display("FAIL random_c%0d: got led/stable/rise %h expected %h", c,
                 {led, sw_stable, sw_rise}, {m_led, m_stable, m_rise});
      else n_pass++;
    end
    rst = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; sw = 4'h0; mode = 2'b00;
    model_reset();
    test_reset();
    test_direct_latency();
    test_glitch();
    test_toggle();
    test_count_clr();
    test_blink_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
